delta_encoding_mul_pipe: RTL
============================

Name: delta_encoding_mul_pipe

Overview:
- Parametrised, pipelined integer multiplier for the SNN delta-encoding datapath.
- Successor to the fixed-width, purely combinational unsigned multiplier instances.
- Adds a configurable pipeline depth, per-operand signedness, truncate-or-saturate output, a valid pipeline, and a clock-enable stall.
- Sits between the delta/threshold computation and the spike-accumulation stage.

Parameters:
- ID, 1: instance identifier; no functional effect.
- NUM_STAGE, 2: pipeline latency in cycles; legal range 1..6.
- din0_WIDTH, 5: width of operand 0.
- din1_WIDTH, 11: width of operand 1.
- dout_WIDTH, 15: width of the result.
- DIN0_SIGNED, 0: 1 = din0 is two's complement; 0 = unsigned.
- DIN1_SIGNED, 0: 1 = din1 is two's complement; 0 = unsigned.
- SAT_MODE, 0: 0 = wrap (keep low dout_WIDTH bits); 1 = saturate to the dout range.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; 0 freezes every pipeline register.
- in_valid  in  1  din0/din1 carry a valid operand pair this cycle.
- din0  in  din0_WIDTH  operand 0.
- din1  in  din1_WIDTH  operand 1.
- out_valid  out  1  dout/sat are valid this cycle.
- dout  out  dout_WIDTH  product, wrapped or saturated per SAT_MODE.
- sat  out  1  result was clamped; only ever 1 when SAT_MODE=1 and out_valid=1.

Behaviour:
- Reset: reset=1 at a clock edge clears all valid bits, dout, sat and all data registers to 0, regardless of ce. It takes priority over ce. In-flight data is discarded; nothing is emitted for it after reset releases.
- Operand extension:
  - Each operand is extended by 1 bit: sign-extended if its *_SIGNED=1, zero-extended otherwise.
  - Full product width FW = din0_WIDTH + din1_WIDTH + 2; the full product is exact.
- Result domain: signed if DIN0_SIGNED or DIN1_SIGNED is 1; unsigned otherwise.
- SAT_MODE=0: dout = FW product [dout_WIDTH-1:0]; sat=0.
- SAT_MODE=1, signed domain:
  - clamp to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
- SAT_MODE=1, unsigned domain:
  - clamp to [0, 2^dout_WIDTH - 1].
- sat=1 exactly when the clamp changed the value.
- If dout_WIDTH >= the natural product width, saturation never triggers.
- Pipeline:
  - Stage 1 registers the extended operands and in_valid.
  - The multiply occupies the middle stages.
  - The final stage registers the clamped/wrapped result and sat.
  - With NUM_STAGE=1, the multiply and clamp are combinational ahead of the single output register.
- Latency: a pair sampled at edge k with ce=1 and in_valid=1 appears with out_valid=1 after exactly NUM_STAGE edges at which ce=1.
- Throughput: one pair per ce=1 cycle. Back-to-back pairs emerge back-to-back, in order.
- ce=0: all registers, including out_valid/dout/sat, hold their values. in_valid is ignored that cycle, so no pair is accepted.
- Bubbles: in_valid=0 with ce=1 inserts a bubble. The bubble propagates as out_valid=0.
- dout on out_valid=0 cycles: don't-care for checking, but must be deterministic; the data registers load regardless of valid.
- No backpressure beyond ce. The downstream consumer stalls the block by dropping ce.
- Corner values that must be exact:
  - most-negative × most-negative in signed mode, e.g. -16 × -1024 = 16384.
  - 0 × anything = 0 with sat=0.

Test Plan:
1. Defaults (unsigned, SAT_MODE=0, NUM_STAGE=2): din0=31, din1=2047, in_valid=1 for 1 cycle -> 2 cycles later out_valid=1, dout=30689 (63457 mod 32768), sat=0.
2. Same operands with SAT_MODE=1 -> dout=32767, sat=1. Then din0=3, din1=100 -> dout=300, sat=0.
3. DIN0_SIGNED=1, SAT_MODE=1: din0=5'b11111 (-1), din1=3 -> dout=15'h7FFD (-3), sat=0. Then din0=5'b10000 (-16), din1=2047 -> dout=15'h4000 (-16384), sat=1.
4. Streaming with a stall, NUM_STAGE=3: 4 consecutive pairs (1×1, 2×2, 3×3, 4×4) with ce=0 for 2 cycles mid-stream -> outputs 1, 4, 9, 16 in order. Outputs and out_valid hold during the stall; total latency per pair = 3 ce=1 edges.
5. Reset mid-flight: 2 pairs in flight, reset=1 for 1 cycle -> out_valid=0, dout=0, sat=0 next cycle. No stale result ever appears afterwards.
6. Parameter sweep (NUM_STAGE 1..6, random signedness/SAT_MODE, 10k random pairs) -> every output matches the reference model after exactly NUM_STAGE ce=1 edges.

Source files
------------

// File: rtl/delta_encoding_mul_pipe.sv
// rtl/delta_encoding_mul_pipe.sv - pipelined multiplier with per-operand signedness and wrap/saturate output
// Valid bits travel alongside the data registers; ce freezes every register, reset clears them all.
module delta_encoding_mul_pipe #(
   parameter int ID          = 1,
   parameter int NUM_STAGE   = 2,
   parameter int din0_WIDTH  = 5,
   parameter int din1_WIDTH  = 11,
   parameter int dout_WIDTH  = 15,
   parameter int DIN0_SIGNED = 0,
   parameter int DIN1_SIGNED = 0,
   parameter int SAT_MODE    = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  sat
);

   localparam int E0 = din0_WIDTH + 1;
   localparam int E1 = din1_WIDTH + 1;
   localparam int FW = E0 + E1;
   // One spare bit so the unsigned upper bound is still positive when compared as signed.
   localparam int XW = ((dout_WIDTH > FW) ? dout_WIDTH : FW) + 1;
   localparam bit SIGNED_DOM = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

   localparam logic signed [XW-1:0] SMAX = (XW'(1) << (dout_WIDTH - 1)) - XW'(1);
   localparam logic signed [XW-1:0] SMIN = XW'(0) - (XW'(1) << (dout_WIDTH - 1));
   localparam logic signed [XW-1:0] UMAX = (XW'(1) << dout_WIDTH) - XW'(1);

   if (NUM_STAGE < 1 || NUM_STAGE > 6 || ID < 0) begin : g_bad_param
      $error("delta_encoding_mul_pipe: NUM_STAGE must be 1..6 and ID non-negative");
   end

   logic signed [E0-1:0]  a_ext;
   logic signed [E1-1:0]  b_ext;
   logic signed [FW-1:0]  prod;
   logic signed [XW-1:0]  pc;
   logic [NUM_STAGE-1:0]  valid_q, valid_d;
   logic [dout_WIDTH-1:0] dout_q, dout_d;
   logic                  sat_q, sat_d, sat_raw;

   always_comb begin
      a_ext = {(DIN0_SIGNED != 0) && din0[din0_WIDTH-1], din0};
      b_ext = {(DIN1_SIGNED != 0) && din1[din1_WIDTH-1], din1};
   end

   always_comb begin
      valid_d    = '0;
      valid_d[0] = in_valid;
      for (int i = 1; i < NUM_STAGE; i++) begin
         valid_d[i] = valid_q[i-1];
      end
   end

   if (NUM_STAGE == 1) begin : g_comb
      always_comb prod = FW'(a_ext) * FW'(b_ext);
   end else begin : g_piped
      logic signed [E0-1:0] a_q, a_d;
      logic signed [E1-1:0] b_q, b_d;

      always_comb begin
         a_d = a_ext;
         b_d = b_ext;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            a_q <= '0;
            b_q <= '0;
         end else if (ce) begin
            a_q <= a_d;
            b_q <= b_d;
         end
      end

      if (NUM_STAGE == 2) begin : g_s2
         always_comb prod = FW'(a_q) * FW'(b_q);
      end else begin : g_deep
         // Multiply lands in the first middle register; the trailing registers give retiming room.
         localparam int PD = NUM_STAGE - 2;
         logic signed [FW-1:0] prod_q [PD];
         logic signed [FW-1:0] prod_d [PD];

         always_comb begin
            prod_d[0] = FW'(a_q) * FW'(b_q);
            for (int i = 1; i < PD; i++) begin
               prod_d[i] = prod_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < PD; i++) prod_q[i] <= '0;
            end else if (ce) begin
               for (int i = 0; i < PD; i++) prod_q[i] <= prod_d[i];
            end
         end

         always_comb prod = prod_q[PD-1];
      end
   end

   always_comb begin
      pc      = XW'(prod);
      dout_d  = pc[dout_WIDTH-1:0];
      sat_raw = 1'b0;
      if (SAT_MODE != 0) begin
         if (SIGNED_DOM) begin
            if (pc > SMAX) begin
               dout_d  = SMAX[dout_WIDTH-1:0];
               sat_raw = 1'b1;
            end else if (pc < SMIN) begin
               dout_d  = SMIN[dout_WIDTH-1:0];
               sat_raw = 1'b1;
            end
         end else if (pc > UMAX) begin
            dout_d  = UMAX[dout_WIDTH-1:0];
            sat_raw = 1'b1;
         end
      end
      // sat is qualified so a bubble never reports a clamp.
      sat_d = sat_raw && valid_d[NUM_STAGE-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         dout_q  <= '0;
         sat_q   <= 1'b0;
      end else if (ce) begin
         valid_q <= valid_d;
         dout_q  <= dout_d;
         sat_q   <= sat_d;
      end
   end

   assign out_valid = valid_q[NUM_STAGE-1];
   assign dout      = dout_q;
   assign sat       = sat_q;

endmodule
